system_ctrl: RTL and testbench
==============================

Name: system_ctrl

Overview:
- Command-side system block for the FPGA motion controller, successor to the fixed single-purpose system handler.
- Handles version/capability query, two-word time sync against a latched sync pulse, time readback, commanded shutdown, and a new host watchdog.
- Aggregates NFAULT generic fault inputs into a sticky shutdown reason and reports it once via the involuntary-response channel.
- Sits between the command decoder (cmd/arg stream) and the response framer (param stream).

Parameters:
- CMD_BITS, 6: command code width.
- CMD_GET_VERSION / CMD_SYNC_TIME / CMD_GET_TIME / CMD_SHUTDOWN / CMD_WATCHDOG, 0/1/2/3/4: command codes.
- RSP_GET_VERSION / RSP_GET_TIME / RSP_SHUTDOWN, 0/1/2: response codes.
- VERSION, 0: first version response word.
- NINFO, 4: number of capability words following VERSION, 1..16.
- INFO, 0: NINFO*32-bit flat vector of capability words; word i is INFO[32*i+31:32*i].
- NFAULT, 8: fault input count, 1..31.
- SYNC_LATENCY, 4: constant added in time sync (2 sync FFs, 1 latch, 1 apply).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- systime  in  32  current system time, low word
- arg_data  in  32  current argument word
- arg_advance  out  1  constant 1; one argument consumed per clk
- cmd  in  CMD_BITS  command code
- cmd_ready  in  1  command valid
- cmd_done  out  1  one-cycle command/response complete pulse
- param_data  out  33  response word / response code
- param_write  out  1  param_data valid as response word
- invol_req  out  1  request involuntary response slot
- invol_grant  in  1  slot granted
- time_in  in  64  current 64-bit time
- time_out  out  64  new time value
- time_out_en  out  1  one-cycle load strobe for time_out
- timesync_latch_in  in  1  asynchronous sync pulse
- fault  in  NFAULT  level fault sources, active-high
- shutdown  out  1  sticky shutdown

Behaviour:
- Reset: async assert clears every output, latched_time, fault_lat, wd_cnt, wd_armed, sync FFs and prev_latch; state=IDLE; time_out=0.
- arg_advance is exempt: tied to constant 1, so it stays 1 during reset.
- Sync pulse: double-FF synchroniser. On its synchronised falling edge, latched_time<=time_in; this works in any state.
- Commands are accepted only in IDLE with cmd_ready. Unknown codes are dropped with no cmd_done.
- GET_VERSION:
  - Write VERSION, then INFO words 0..NINFO-1 on consecutive cycles (1+NINFO cycles with param_write=1).
  - Next cycle: param_write=0, param_data=RSP_GET_VERSION, cmd_done=1.
- SYNC_TIME:
  - The accept cycle captures arg_data as the low word; the next cycle uses arg_data as the high word.
  - Then time_out<=time_in-latched_time+{hi,lo}+SYNC_LATENCY, computed mod 2^64.
  - time_out_en=1 and cmd_done=1 for one cycle.
- GET_TIME:
  - Write time_in[31:0], then the high word captured in the same accept cycle (coherent snapshot).
  - Then RSP_GET_TIME with cmd_done.
- SHUTDOWN: shutdown<=1 and cmd_done=1 the cycle after accept. No response words.
- WATCHDOG:
  - arg_data = timeout in clk cycles. wd_cnt<=arg; wd_armed<=(arg!=0); cmd_done next cycle.
  - Reissuing reloads the counter; arg 0 disarms.
  - While armed, wd_cnt decrements each cycle. The transition to 0 sets fault_lat[NFAULT] and disarms.
- Fault latch: fault_lat[NFAULT-1:0] |= fault every cycle while !shutdown. The register is frozen once shutdown=1.
- Involuntary shutdown sequence:
  - Triggered in IDLE, when no cmd_ready, fault_lat!=0 and !shutdown: invol_req<=1, go to WAIT_GRANT.
  - WAIT_GRANT holds indefinitely. While waiting, commands are not accepted and faults keep accumulating.
  - On invol_grant: invol_req<=0; write zero-extended fault_lat (snapshot at grant).
  - Next cycle: write systime.
  - Next cycle: RSP_SHUTDOWN, cmd_done, shutdown<=1.
- A command in IDLE takes priority over a same-cycle fault trigger; the fault is reported after that command completes.
- After shutdown=1, commands are still served, no further involuntary reports occur, and the watchdog is inert.
- Only rst clears shutdown.
- cmd_done and time_out_en are single-cycle pulses. param_write is never high in the cmd_done cycle.

Test Plan:
- NINFO=2, INFO={0x22,0x11}, VERSION=7, GET_VERSION -> writes 7,0x11,0x22 on 3 consecutive cycles, then param_data=RSP_GET_VERSION, cmd_done=1, param_write=0.
- Sync pulse falls when time_in=1000; later SYNC_TIME args 0x10,0x0 with time_in=1500 at compute -> time_out=0x10+500+4=0x208, time_out_en one cycle.
- GET_TIME with time_in=0x00000001_FFFFFFFF at accept -> writes 0xFFFFFFFF then 0x1, even though time_in advances between the writes.
- WATCHDOG arg 5 and no reload -> invol_req rises about 5 cycles later; grant after 3 cycles -> reason word has bit NFAULT set, then systime, RSP_SHUTDOWN, shutdown=1. Second test: reload before expiry, then arg 0 -> no trigger.
- fault[2] pulses for 1 cycle while GET_VERSION is in progress; fault[0] rises during WAIT_GRANT -> after the version response, reason word=0x5 at grant.
- Assert rst mid GET_VERSION -> all outputs 0 (arg_advance remains 1) immediately, no cmd_done. After release, SHUTDOWN -> shutdown=1; a new fault -> no invol_req.

Source files
------------

// File: rtl/system_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : system_ctrl
//  Purpose  : Command-side system block of the motion controller. Serves
//             version/capability query, two-word time sync against a latched
//             sync pulse, coherent time readback, commanded shutdown and a
//             host watchdog. Generic faults and watchdog expiry accumulate
//             into a sticky reason word that is reported once through the
//             involuntary-response slot, after which shutdown is held.
//  Ports    : clk, rst (async, active-high)
//             cmd / cmd_ready / arg_data / arg_advance  - command decoder side
//             param_data / param_write / cmd_done        - response framer side
//             invol_req / invol_grant                    - involuntary slot
//             systime, time_in, time_out, time_out_en    - time base
//             timesync_latch_in                          - async sync pulse
//             fault, shutdown                            - fault aggregation
//  Revision : 1.0  initial release
// ============================================================================
module system_ctrl #(
    parameter int                    CMD_BITS        = 6,
    parameter int                    CMD_GET_VERSION = 0,
    parameter int                    CMD_SYNC_TIME   = 1,
    parameter int                    CMD_GET_TIME    = 2,
    parameter int                    CMD_SHUTDOWN    = 3,
    parameter int                    CMD_WATCHDOG    = 4,
    parameter int                    RSP_GET_VERSION = 0,
    parameter int                    RSP_GET_TIME    = 1,
    parameter int                    RSP_SHUTDOWN    = 2,
    parameter logic [31:0]           VERSION         = 32'd0,
    parameter int                    NINFO           = 4,
    parameter logic [NINFO*32-1:0]   INFO            = '0,
    parameter int                    NFAULT          = 8,
    parameter int                    SYNC_LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          systime,
    input  logic [31:0]          arg_data,
    output logic                 arg_advance,
    input  logic [CMD_BITS-1:0]  cmd,
    input  logic                 cmd_ready,
    output logic                 cmd_done,
    output logic [32:0]          param_data,
    output logic                 param_write,
    output logic                 invol_req,
    input  logic                 invol_grant,
    input  logic [63:0]          time_in,
    output logic [63:0]          time_out,
    output logic                 time_out_en,
    input  logic                 timesync_latch_in,
    input  logic [NFAULT-1:0]    fault,
    output logic                 shutdown
);

    localparam int IDX_W = (NINFO > 1) ? $clog2(NINFO) : 1;

    localparam logic [CMD_BITS-1:0] c_cmd_ver  = CMD_BITS'(CMD_GET_VERSION);
    localparam logic [CMD_BITS-1:0] c_cmd_sync = CMD_BITS'(CMD_SYNC_TIME);
    localparam logic [CMD_BITS-1:0] c_cmd_time = CMD_BITS'(CMD_GET_TIME);
    localparam logic [CMD_BITS-1:0] c_cmd_shut = CMD_BITS'(CMD_SHUTDOWN);
    localparam logic [CMD_BITS-1:0] c_cmd_wd   = CMD_BITS'(CMD_WATCHDOG);
    localparam logic [31:0]         c_rsp_ver  = 32'(RSP_GET_VERSION);
    localparam logic [31:0]         c_rsp_time = 32'(RSP_GET_TIME);
    localparam logic [31:0]         c_rsp_shut = 32'(RSP_SHUTDOWN);
    localparam logic [63:0]         c_sync_lat = 64'(SYNC_LATENCY);
    localparam logic [IDX_W-1:0]    c_last_idx = IDX_W'(NINFO - 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_VER        = 4'd1,   // streaming capability words
        S_SYNC_HI    = 4'd2,   // waiting for the high sync argument
        S_TIME_HI    = 4'd3,   // writing the captured high time word
        S_RSP        = 4'd4,   // emit response code with cmd_done
        S_DONE       = 4'd5,   // cmd_done visible; blocks re-accept
        S_WAIT_GRANT = 4'd6,
        S_INV_TIME   = 4'd7,   // writing systime of the shutdown report
        S_INV_RSP    = 4'd8
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [31:0]         r_word;       // sync low arg or GET_TIME high snapshot
    logic [31:0]         r_rsp;
    logic [63:0]         r_latched_time;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_prev_latch;
    logic [NFAULT:0]     r_fault_lat;  // top bit is watchdog expiry
    logic [31:0]         r_wd_cnt;
    logic                r_wd_armed;

    logic                r_cmd_done;
    logic [32:0]         r_param_data;
    logic                r_param_write;
    logic                r_invol_req;
    logic [63:0]         r_time_out;
    logic                r_time_out_en;
    logic                r_shutdown;

    logic [31:0]         w_info [NINFO];
    logic                w_wd_load;
    logic                w_wd_expire;

    for (genvar gi = 0; gi < NINFO; gi++) begin : g_info
        assign w_info[gi] = INFO[32*gi +: 32];
    end

    assign w_wd_load   = (r_state == S_IDLE) && cmd_ready && (cmd == c_cmd_wd);
    // A reload on the expiry cycle wins over the expiry.
    assign w_wd_expire = r_wd_armed && !r_shutdown && !w_wd_load && (r_wd_cnt == 32'd1);

    assign arg_advance = 1'b1;
    assign cmd_done    = r_cmd_done;
    assign param_data  = r_param_data;
    assign param_write = r_param_write;
    assign invol_req   = r_invol_req;
    assign time_out    = r_time_out;
    assign time_out_en = r_time_out_en;
    assign shutdown    = r_shutdown;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_word         <= '0;
            r_rsp          <= '0;
            r_latched_time <= '0;
            r_sync1        <= 1'b0;
            r_sync2        <= 1'b0;
            r_prev_latch   <= 1'b0;
            r_fault_lat    <= '0;
            r_wd_cnt       <= '0;
            r_wd_armed     <= 1'b0;
            r_cmd_done     <= 1'b0;
            r_param_data   <= '0;
            r_param_write  <= 1'b0;
            r_invol_req    <= 1'b0;
            r_time_out     <= '0;
            r_time_out_en  <= 1'b0;
            r_shutdown     <= 1'b0;
        end else begin
            // Sync pulse: latch the time base on the synchronised falling edge.
            r_sync1      <= timesync_latch_in;
            r_sync2      <= r_sync1;
            r_prev_latch <= r_sync2;
            if (r_prev_latch && !r_sync2) begin
                r_latched_time <= time_in;
            end

            r_cmd_done    <= 1'b0;
            r_param_write <= 1'b0;
            r_time_out_en <= 1'b0;

            if (w_wd_load) begin
                r_wd_cnt   <= arg_data;
                r_wd_armed <= (arg_data != 32'd0);
            end else if (r_wd_armed && !r_shutdown) begin
                r_wd_cnt <= r_wd_cnt - 32'd1;
                if (r_wd_cnt == 32'd1) begin
                    r_wd_armed <= 1'b0;
                end
            end

            // The reason word is frozen once shutdown is reported.
            if (!r_shutdown) begin
                r_fault_lat <= r_fault_lat | {w_wd_expire, fault};
            end

            case (r_state)
                S_IDLE: begin
                    if (cmd_ready) begin
                        if (cmd == c_cmd_ver) begin
                            r_param_data  <= {1'b0, VERSION};
                            r_param_write <= 1'b1;
                            r_idx         <= '0;
                            r_state       <= S_VER;
                        end else if (cmd == c_cmd_sync) begin
                            r_word  <= arg_data;
                            r_state <= S_SYNC_HI;
                        end else if (cmd == c_cmd_time) begin
                            // Capture both halves now so the readback is coherent.
                            r_param_data  <= {1'b0, time_in[31:0]};
                            r_param_write <= 1'b1;
                            r_word        <= time_in[63:32];
                            r_state       <= S_TIME_HI;
                        end else if (cmd == c_cmd_shut) begin
                            r_shutdown <= 1'b1;
                            r_cmd_done <= 1'b1;
                            r_state    <= S_DONE;
                        end else if (cmd == c_cmd_wd) begin
                            r_cmd_done <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end else if ((r_fault_lat != '0) && !r_shutdown) begin
                        r_invol_req <= 1'b1;
                        r_state     <= S_WAIT_GRANT;
                    end
                end

                S_VER: begin
                    r_param_data  <= {1'b0, w_info[r_idx]};
                    r_param_write <= 1'b1;
                    if (r_idx == c_last_idx) begin
                        r_rsp   <= c_rsp_ver;
                        r_state <= S_RSP;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                S_SYNC_HI: begin
                    r_time_out    <= time_in - r_latched_time + {arg_data, r_word} + c_sync_lat;
                    r_time_out_en <= 1'b1;
                    r_cmd_done    <= 1'b1;
                    r_state       <= S_DONE;
                end

                S_TIME_HI: begin
                    r_param_data  <= {1'b0, r_word};
                    r_param_write <= 1'b1;
                    r_rsp         <= c_rsp_time;
                    r_state       <= S_RSP;
                end

                S_RSP: begin
                    r_param_data <= {1'b0, r_rsp};
                    r_cmd_done   <= 1'b1;
                    r_state      <= S_DONE;
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                S_WAIT_GRANT: begin
                    if (invol_grant) begin
                        r_invol_req   <= 1'b0;
                        r_param_data  <= 33'(r_fault_lat);
                        r_param_write <= 1'b1;
                        r_state       <= S_INV_TIME;
                    end
                end

                S_INV_TIME: begin
                    r_param_data  <= {1'b0, systime};
                    r_param_write <= 1'b1;
                    r_state       <= S_INV_RSP;
                end

                S_INV_RSP: begin
                    r_param_data <= {1'b0, c_rsp_shut};
                    r_cmd_done   <= 1'b1;
                    r_shutdown   <= 1'b1;
                    r_state      <= S_DONE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_system_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_system_ctrl
//  Purpose  : Self-checking bench for system_ctrl. Directed steps with
//             randomised operands; expected values come from plain arithmetic
//             on the command semantics (time deltas, OR-accumulated faults,
//             fixed capability word list).
//  Revision : 1.0  initial release
// ============================================================================
module tb_system_ctrl;

    localparam int          NF      = 8;
    localparam logic [5:0]  C_VER   = 6'd0;
    localparam logic [5:0]  C_SYNC  = 6'd1;
    localparam logic [5:0]  C_TIME  = 6'd2;
    localparam logic [5:0]  C_SHUT  = 6'd3;
    localparam logic [5:0]  C_WD    = 6'd4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   systime;
    logic [31:0]   arg_data;
    logic          arg_advance;
    logic [5:0]    cmd;
    logic          cmd_ready;
    logic          cmd_done;
    logic [32:0]   param_data;
    logic          param_write;
    logic          invol_req;
    logic          invol_grant;
    logic [63:0]   time_in;
    logic [63:0]   time_out;
    logic          time_out_en;
    logic          timesync_latch_in;
    logic [NF-1:0] fault;
    logic          shutdown;

    int checks = 0;
    int errors = 0;

    // Expected version response: VERSION then the capability words in order.
    logic [31:0] ver_words [3] = '{32'd7, 32'h11, 32'h22};

    system_ctrl #(
        .VERSION (32'd7),
        .NINFO   (2),
        .INFO    (64'h00000022_00000011),
        .NFAULT  (NF)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .systime           (systime),
        .arg_data          (arg_data),
        .arg_advance       (arg_advance),
        .cmd               (cmd),
        .cmd_ready         (cmd_ready),
        .cmd_done          (cmd_done),
        .param_data        (param_data),
        .param_write       (param_write),
        .invol_req         (invol_req),
        .invol_grant       (invol_grant),
        .time_in           (time_in),
        .time_out          (time_out),
        .time_out_en       (time_out_en),
        .timesync_latch_in (timesync_latch_in),
        .fault             (fault),
        .shutdown          (shutdown)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present a command for one accept edge; returns at the negedge of the
    // first cycle after acceptance.
    task automatic issue(input logic [5:0] code, input logic [31:0] arg);
        cmd       = code;
        arg_data  = arg;
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        cmd       = 6'($urandom);
        arg_data  = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_version(input int fault_at, input logic [NF-1:0] fval);
        issue(C_VER, $urandom);
        for (int i = 0; i < 3; i++) begin
            chk("ver_pw", param_write, 1);
            chk("ver_word", param_data, 64'(ver_words[i]));
            chk("ver_done_low", cmd_done, 0);
            chk("ver_no_invol", invol_req, 0);
            fault = (i == fault_at) ? fval : '0;
            @(negedge clk);
        end
        fault = '0;
        chk("ver_rsp_pw", param_write, 0);
        chk("ver_rsp", param_data, 0);
        chk("ver_done", cmd_done, 1);
        @(negedge clk);
        chk("ver_done_pulse", cmd_done, 0);
    endtask

    task automatic run_sync(input logic [63:0] tl, input logic [63:0] tc, input logic [63:0] a);
        time_in = tl;
        timesync_latch_in = 1'b1;
        repeat (3) @(negedge clk);
        timesync_latch_in = 1'b0;
        repeat (5) @(negedge clk);
        time_in = tc;
        issue(C_SYNC, a[31:0]);
        arg_data = a[63:32];
        chk("sync_en_early", time_out_en, 0);
        @(negedge clk);
        chk("sync_time_out", time_out, tc - tl + a + 64'd4);
        chk("sync_en", time_out_en, 1);
        chk("sync_done", cmd_done, 1);
        chk("sync_pw", param_write, 0);
        @(negedge clk);
        chk("sync_en_pulse", time_out_en, 0);
        chk("sync_done_pulse", cmd_done, 0);
    endtask

    task automatic run_time(input logic [63:0] t0, input logic [63:0] t1);
        time_in = t0;
        issue(C_TIME, $urandom);
        time_in = t1;
        chk("time_lo", param_data, 64'(t0[31:0]));
        chk("time_lo_pw", param_write, 1);
        @(negedge clk);
        chk("time_hi", param_data, 64'(t0[63:32]));
        chk("time_hi_pw", param_write, 1);
        @(negedge clk);
        chk("time_rsp", param_data, 1);
        chk("time_rsp_pw", param_write, 0);
        chk("time_done", cmd_done, 1);
        @(negedge clk);
        chk("time_done_pulse", cmd_done, 0);
    endtask

    initial begin
        int             cnt;
        int             n;
        logic [NF-1:0]  acc;
        logic [31:0]    st;
        logic [5:0]     bad;

        rst = 1'b1;
        systime = '0; arg_data = '0; cmd = '0; cmd_ready = 1'b0;
        invol_grant = 1'b0; time_in = '0; timesync_latch_in = 1'b0; fault = '0;
        repeat (2) @(negedge clk);

        chk("rst_param_data", param_data, 0);
        chk("rst_param_write", param_write, 0);
        chk("rst_cmd_done", cmd_done, 0);
        chk("rst_invol_req", invol_req, 0);
        chk("rst_time_out", time_out, 0);
        chk("rst_time_out_en", time_out_en, 0);
        chk("rst_shutdown", shutdown, 0);
        chk("rst_arg_advance", arg_advance, 1);
        rst = 1'b0;
        @(negedge clk);

        // Version query, twice with random idle gaps.
        repeat (2) begin
            run_version(-1, '0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Time sync: directed vector then random ones.
        run_sync(64'd1000, 64'd1500, 64'h10);
        repeat (3) run_sync({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});

        // Coherent time readback.
        run_time(64'h0000_0001_FFFF_FFFF, 64'h0000_0002_0000_0003);
        repeat (3) run_time({$urandom, $urandom}, {$urandom, $urandom});

        // Unknown command: dropped silently.
        bad = 6'($urandom_range(5, 63));
        issue(bad, $urandom);
        for (int i = 0; i < 4; i++) begin
            chk("unk_done", cmd_done, 0);
            chk("unk_pw", param_write, 0);
            @(negedge clk);
        end

        // Watchdog reload then disarm: must never fire.
        issue(C_WD, 32'd5);
        chk("wd_done", cmd_done, 1);
        repeat (2) @(negedge clk);
        issue(C_WD, 32'd5);
        chk("wd_reload_done", cmd_done, 1);
        repeat (2) @(negedge clk);
        issue(C_WD, 32'd0);
        chk("wd_disarm_done", cmd_done, 1);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (invol_req) cnt++;
        end
        chk("wd_disarmed_no_invol", cnt, 0);

        // Watchdog expiry leads to an involuntary shutdown report.
        n  = $urandom_range(3, 12);
        st = $urandom;
        systime = st;
        issue(C_WD, 32'(n));
        chk("wdt_done", cmd_done, 1);
        cnt = 1;
        while (!invol_req && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("wdt_invol_seen", invol_req, 1);
        chk("wdt_latency_window", 64'(cnt >= n && cnt <= n + 3), 1);
        issue(C_TIME, $urandom);   // must be ignored while waiting for grant
        for (int i = 0; i < 2; i++) begin
            chk("wdt_wait_req", invol_req, 1);
            chk("wdt_wait_pw", param_write, 0);
            chk("wdt_wait_done", cmd_done, 0);
            @(negedge clk);
        end
        invol_grant = 1'b1;
        @(negedge clk);
        invol_grant = 1'b0;
        chk("wdt_req_drop", invol_req, 0);
        chk("wdt_reason_pw", param_write, 1);
        chk("wdt_reason", param_data, 64'(1) << NF);
        @(negedge clk);
        chk("wdt_systime", param_data, 64'(st));
        chk("wdt_systime_pw", param_write, 1);
        @(negedge clk);
        chk("wdt_rsp", param_data, 2);
        chk("wdt_rsp_pw", param_write, 0);
        chk("wdt_rsp_done", cmd_done, 1);
        chk("wdt_shutdown", shutdown, 1);
        @(negedge clk);
        chk("wdt_done_pulse", cmd_done, 0);

        // After shutdown: commands still served, watchdog inert.
        run_version(-1, '0);
        issue(C_WD, 32'd2);
        chk("post_wd_done", cmd_done, 1);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (invol_req) cnt++;
        end
        chk("post_wd_inert", cnt, 0);
        chk("post_shutdown_held", shutdown, 1);

        // Faults accumulated during a command and while waiting for grant.
        do_reset();
        chk("fr_shutdown_cleared", shutdown, 0);
        acc = '0;
        run_version(1, 8'h04);
        acc |= 8'h04;
        cnt = 0;
        while (!invol_req && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("fr_invol_seen", invol_req, 1);
        fault = 8'h01;
        acc  |= 8'h01;
        @(negedge clk);
        fault = '0;
        @(negedge clk);
        st = $urandom;
        systime = st;
        invol_grant = 1'b1;
        @(negedge clk);
        invol_grant = 1'b0;
        chk("fr_reason", param_data, 64'(acc));
        chk("fr_reason_pw", param_write, 1);
        @(negedge clk);
        chk("fr_systime", param_data, 64'(st));
        @(negedge clk);
        chk("fr_rsp", param_data, 2);
        chk("fr_rsp_done", cmd_done, 1);
        chk("fr_shutdown", shutdown, 1);
        @(negedge clk);

        // Asynchronous reset in the middle of a version response.
        do_reset();
        run_sync({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, 32'h1});
        issue(C_VER, $urandom);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_param_data", param_data, 0);
        chk("arst_param_write", param_write, 0);
        chk("arst_cmd_done", cmd_done, 0);
        chk("arst_invol_req", invol_req, 0);
        chk("arst_time_out", time_out, 0);
        chk("arst_time_out_en", time_out_en, 0);
        chk("arst_shutdown", shutdown, 0);
        chk("arst_arg_advance", arg_advance, 1);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (cmd_done || param_write) cnt++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (cmd_done || param_write) cnt++;
        end
        chk("arst_no_resume", cnt, 0);
        issue(C_SHUT, $urandom);
        chk("shut_done", cmd_done, 1);
        chk("shut_shutdown", shutdown, 1);
        chk("shut_pw", param_write, 0);
        @(negedge clk);
        chk("shut_done_pulse", cmd_done, 0);
        fault = 8'h08;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (invol_req) cnt++;
        end
        fault = '0;
        chk("shut_no_invol", cnt, 0);
        chk("shut_held", shutdown, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
